// File: rtl/ddr3_frame_pkg.sv
// Shared types for the DDR3 triple-buffer frame scheduler: FSM encoding,
// bank indexing and bank base-address arithmetic.
package ddr3_frame_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DELAY    = 2'd1,
      WAIT_SOF = 2'd2,
      STREAM   = 2'd3
   } state_t;

   localparam int BANK_W    = 2;
   localparam int NUM_BANKS = 3;
   localparam int PIX_LAT   = 2;

   typedef logic [BANK_W-1:0] bank_t;

   // Callers truncate to their address width, which gives the mod-2^N wrap.
   function automatic logic [63:0] bank_base(input bank_t bank,
                                             input logic [63:0] base,
                                             input logic [63:0] stride);
      return base + 64'(bank) * stride;
   endfunction

endpackage

// File: rtl/ddr3_frame_sched_if.sv
// Pixel-in, DDR3 write/read request and status bundle for ddr3_frame_sched.
interface ddr3_frame_sched_if #(
   parameter int ADDR_WIDTH    = 28,
   parameter int DATA_IN_WIDTH = 16
);
   logic [DATA_IN_WIDTH-1:0] pix_data;
   logic                     pix_vld;
   logic                     pix_sof;
   logic                     wr_req;
   logic [ADDR_WIDTH-1:0]    wr_address_begin;
   logic [ADDR_WIDTH-1:0]    wr_address_end;
   logic [DATA_IN_WIDTH-1:0] wr_din;
   logic                     wr_din_vld;
   logic                     rd_frame_req;
   logic                     rd_req;
   logic [ADDR_WIDTH-1:0]    rd_address_begin;
   logic [ADDR_WIDTH-1:0]    rd_address_end;
   logic                     frame_valid;
   logic [15:0]              drop_cnt;

   modport master (
      output pix_data, pix_vld, pix_sof, rd_frame_req,
      input  wr_req, wr_address_begin, wr_address_end, wr_din, wr_din_vld,
             rd_req, rd_address_begin, rd_address_end, frame_valid, drop_cnt
   );

   modport slave (
      input  pix_data, pix_vld, pix_sof, rd_frame_req,
      output wr_req, wr_address_begin, wr_address_end, wr_din, wr_din_vld,
             rd_req, rd_address_begin, rd_address_end, frame_valid, drop_cnt
   );
endinterface

// File: rtl/ddr3_frame_sched_bank_sel.sv
// Triple-buffer bank rotation: tracks write, read and last-committed banks,
// forwarding a same-cycle commit into the read selection.
module frame_bank_sel
   import ddr3_frame_pkg::*;
(
   input  logic  wr_clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  commit,
   input  logic  rd_frame_req,
   output bank_t wr_bank,
   output bank_t rd_bank_nxt,
   output logic  rd_fire,
   output logic  frame_valid
);

   bank_t rd_bank, last_bank, last_nxt, wr_nxt;

   function automatic bank_t free_bank(input bank_t a, input bank_t b);
      free_bank = '0;
      for (int i = NUM_BANKS-1; i >= 0; i--)
         if (bank_t'(i) != a && bank_t'(i) != b) free_bank = bank_t'(i);
   endfunction

   always_comb begin
      last_nxt    = commit ? wr_bank : last_bank;
      rd_fire     = rd_frame_req && (frame_valid || commit) && !clr;
      rd_bank_nxt = rd_fire ? last_nxt : rd_bank;
      wr_nxt      = commit ? free_bank(rd_bank_nxt, last_nxt) : wr_bank;
   end

   always_ff @(posedge wr_clk) begin
      if (!rst_n || clr) begin
         wr_bank     <= '0;
         rd_bank     <= '0;
         last_bank   <= '0;
         frame_valid <= 1'b0;
      end else begin
         wr_bank   <= wr_nxt;
         rd_bank   <= rd_bank_nxt;
         last_bank <= last_nxt;
         if (commit) frame_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/ddr3_frame_sched.sv
// Triple-buffer frame scheduler for the DDR3 native-FIFO write port.
// Optional FRAME_SCHED_DROP_CNT_EN enables the saturating short-frame counter.
module ddr3_frame_sched
   import ddr3_frame_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = 28,
   parameter int                    DATA_IN_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] FRAME_BASE    = 28'h100_0000,
   parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE  = 28'h010_0000,
   parameter logic [ADDR_WIDTH-1:0] FRAME_PIX     = 28'h00e_1000,
   parameter int                    DELAY_TIME    = 500
) (
   input  logic                wr_clk,
   input  logic                rst_n,
   input  logic                init_calib_complete,
   ddr3_frame_sched_if.slave   bus
);

   localparam int                    DLY_W    = $clog2(DELAY_TIME + 1);
   localparam logic [DLY_W-1:0]      DLY_LAST = DLY_W'(DELAY_TIME - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_PIX = FRAME_PIX - 1'b1;

   state_t                  state, state_nxt;
   logic [DLY_W-1:0]        dly_cnt;
   logic [ADDR_WIDTH-1:0]   pix_cnt;
   logic                    calib, pix_acc, sof_hit, commit, short_frame;
   logic [PIX_LAT:1]        vld_pipe;
   logic [PIX_LAT:1][DATA_IN_WIDTH-1:0] data_pipe;
   bank_t                   wr_bank, rd_bank_nxt;
   logic                    rd_fire;

   assign calib = init_calib_complete;

   function automatic logic [ADDR_WIDTH-1:0] bank_addr(input bank_t b);
      return ADDR_WIDTH'(bank_base(b, 64'(FRAME_BASE), 64'(FRAME_STRIDE)));
   endfunction

   always_ff @(posedge wr_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pix_acc     = 1'b0;
      sof_hit     = 1'b0;
      commit      = 1'b0;
      short_frame = 1'b0;
      case (state)
         IDLE:     if (calib) state_nxt = DELAY;
         DELAY:    if (dly_cnt == DLY_LAST) state_nxt = WAIT_SOF;
         WAIT_SOF: if (bus.pix_vld && bus.pix_sof) begin
            pix_acc   = 1'b1;
            sof_hit   = 1'b1;
            state_nxt = STREAM;
         end
         STREAM:   if (bus.pix_vld) begin
            pix_acc = 1'b1;
            if (bus.pix_sof) begin
               sof_hit     = 1'b1;
               short_frame = 1'b1;
            end else if (pix_cnt == LAST_PIX) begin
               commit    = 1'b1;
               state_nxt = WAIT_SOF;
            end
         end
         default:  state_nxt = IDLE;
      endcase
      // Losing calibration overrides everything, including a pending commit.
      if (!calib) begin
         state_nxt   = IDLE;
         pix_acc     = 1'b0;
         sof_hit     = 1'b0;
         commit      = 1'b0;
         short_frame = 1'b0;
      end
   end

   always_ff @(posedge wr_clk) begin
      if (!rst_n) begin
         dly_cnt <= '0;
         pix_cnt <= '0;
      end else begin
         dly_cnt <= (state == DELAY && calib) ? dly_cnt + 1'b1 : '0;
         if (!calib)       pix_cnt <= '0;
         else if (sof_hit) pix_cnt <= ADDR_WIDTH'(1);
         else if (pix_acc) pix_cnt <= pix_cnt + 1'b1;
      end
   end

   always_ff @(posedge wr_clk) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
      end else begin
         vld_pipe <= calib ? {vld_pipe[PIX_LAT-1:1], pix_acc} : '0;
         if (pix_acc) data_pipe[1] <= bus.pix_data;
         for (int i = 2; i <= PIX_LAT; i++)
            if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
   end

   assign bus.wr_din     = data_pipe[PIX_LAT];
   assign bus.wr_din_vld = vld_pipe[PIX_LAT];

   always_ff @(posedge wr_clk) begin
      if (!rst_n) begin
         bus.wr_req           <= 1'b0;
         bus.wr_address_begin <= '0;
         bus.wr_address_end   <= '0;
         bus.rd_req           <= 1'b0;
         bus.rd_address_begin <= '0;
         bus.rd_address_end   <= '0;
      end else begin
         bus.wr_req <= sof_hit;
         bus.rd_req <= rd_fire;
         if (sof_hit) begin
            bus.wr_address_begin <= bank_addr(wr_bank);
            bus.wr_address_end   <= bank_addr(wr_bank) + FRAME_PIX;
         end
         if (rd_fire) begin
            bus.rd_address_begin <= bank_addr(rd_bank_nxt);
            bus.rd_address_end   <= bank_addr(rd_bank_nxt) + FRAME_PIX;
         end
      end
   end

   frame_bank_sel u_bank_sel (
      .wr_clk       (wr_clk),
      .rst_n        (rst_n),
      .clr          (!calib),
      .commit       (commit),
      .rd_frame_req (bus.rd_frame_req),
      .wr_bank      (wr_bank),
      .rd_bank_nxt  (rd_bank_nxt),
      .rd_fire      (rd_fire),
      .frame_valid  (bus.frame_valid)
   );

`ifdef FRAME_SCHED_DROP_CNT_EN
   logic [15:0] drop_q;
   always_ff @(posedge wr_clk) begin
      if (!rst_n)                              drop_q <= '0;
      else if (short_frame && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
   end
   assign bus.drop_cnt = drop_q;
`else
   logic drop_unused;
   assign drop_unused  = short_frame;
   assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr3_frame_sched.sv
// Directed bench for ddr3_frame_sched: startup gating, write timing, bank
// rotation, read forwarding, short frames and calibration loss.
module tb_ddr3_frame_sched;

   localparam int            AW     = 28;
   localparam int            DW     = 16;
   localparam logic [AW-1:0] BASE   = 28'h100_0000;
   localparam logic [AW-1:0] STRIDE = 28'h100;
   localparam logic [AW-1:0] FPIX   = 28'd16;
`ifdef FRAME_SCHED_DROP_CNT_EN
   localparam logic [15:0]   EXP_DROP = 16'd1;
`else
   localparam logic [15:0]   EXP_DROP = 16'd0;
`endif

   logic wr_clk = 1'b0;
   logic rst_n  = 1'b0;
   logic init_calib_complete = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int            req_cnt = 0, rd_cnt = 0, dbl_cnt = 0;
   logic [AW-1:0] req_beg, req_end;
   logic          prev_wr = 1'b0, prev_rd = 1'b0;
   logic [DW-1:0] din_q[$];

   ddr3_frame_sched_if #(.ADDR_WIDTH(AW), .DATA_IN_WIDTH(DW)) ifc ();

   ddr3_frame_sched #(
      .ADDR_WIDTH(AW), .DATA_IN_WIDTH(DW), .FRAME_BASE(BASE),
      .FRAME_STRIDE(STRIDE), .FRAME_PIX(FPIX), .DELAY_TIME(8)
   ) dut (
      .wr_clk              (wr_clk),
      .rst_n               (rst_n),
      .init_calib_complete (init_calib_complete),
      .bus                 (ifc)
   );

   always #5 wr_clk = ~wr_clk;

   // Observe outputs mid-cycle, away from the active edge.
   always @(negedge wr_clk) begin
      if (ifc.wr_req === 1'b1) begin
         req_cnt++;
         req_beg = ifc.wr_address_begin;
         req_end = ifc.wr_address_end;
      end
      if (ifc.rd_req === 1'b1) rd_cnt++;
      if ((ifc.wr_req === 1'b1 && prev_wr) || (ifc.rd_req === 1'b1 && prev_rd)) dbl_cnt++;
      prev_wr = (ifc.wr_req === 1'b1);
      prev_rd = (ifc.rd_req === 1'b1);
      if (ifc.wr_din_vld === 1'b1) din_q.push_back(ifc.wr_din);
   end

   task automatic tick;
      @(posedge wr_clk);
      #1;
   endtask

   task automatic drive_frame(input logic [DW-1:0] d0, input int n, input bit rd_last);
      for (int i = 0; i < n; i++) begin
         ifc.pix_vld      = 1'b1;
         ifc.pix_sof      = (i == 0);
         ifc.pix_data     = d0 + DW'(i);
         ifc.rd_frame_req = rd_last && (i == n - 1);
         tick;
      end
      ifc.pix_vld      = 1'b0;
      ifc.pix_sof      = 1'b0;
      ifc.rd_frame_req = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      init_calib_complete = 1'b0;
      ifc.pix_vld = 1'b0; ifc.pix_sof = 1'b0; ifc.pix_data = '0; ifc.rd_frame_req = 1'b0;
      repeat (3) tick;
      checks++;
      if ({ifc.wr_req, ifc.rd_req, ifc.wr_din_vld, ifc.frame_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000", {ifc.wr_req, ifc.rd_req, ifc.wr_din_vld, ifc.frame_valid});
      end
      checks++;
      if ((ifc.wr_address_begin | ifc.wr_address_end | ifc.rd_address_begin | ifc.rd_address_end) !== '0) begin
         errors++;
         $display("FAIL reset_addr: got %h %h %h %h want 0", ifc.wr_address_begin, ifc.wr_address_end,
                  ifc.rd_address_begin, ifc.rd_address_end);
      end
      checks++;
      if (ifc.wr_din !== '0 || ifc.drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_din_drop: got din=%h drop=%0d want 0 0", ifc.wr_din, ifc.drop_cnt);
      end
   endtask

   task automatic test_delay;
      int c_req = req_cnt;
      int c_din = din_q.size();
      rst_n = 1'b1;
      init_calib_complete = 1'b1;
      // SOFs during the calibration delay, including its last cycle, are ignored.
      for (int i = 0; i < 9; i++) begin
         ifc.pix_vld = 1'b1; ifc.pix_sof = (i == 4 || i == 8); ifc.pix_data = 16'h0B00 + DW'(i);
         tick;
      end
      ifc.pix_sof = 1'b0;
      repeat (2) tick;
      ifc.pix_vld = 1'b0;
      repeat (3) tick;
      checks++;
      if (req_cnt != c_req) begin
         errors++;
         $display("FAIL delay_no_wr_req: got %0d requests want 0", req_cnt - c_req);
      end
      checks++;
      if (din_q.size() != c_din) begin
         errors++;
         $display("FAIL delay_no_din: got %0d pixels want 0", din_q.size() - c_din);
      end
   endtask

   task automatic test_first_frame;
      int c_din = din_q.size();
      int bad = 0;
      ifc.pix_vld = 1'b1; ifc.pix_sof = 1'b1; ifc.pix_data = 16'hA000;
      tick;
      checks++;
      if (ifc.wr_req !== 1'b1 || ifc.wr_address_begin !== 28'h100_0000 ||
          ifc.wr_address_end !== 28'h100_0010 || ifc.wr_din_vld !== 1'b0) begin
         errors++;
         $display("FAIL first_wr_req: got req=%b beg=%h end=%h vld=%b want 1 1000000 1000010 0",
                  ifc.wr_req, ifc.wr_address_begin, ifc.wr_address_end, ifc.wr_din_vld);
      end
      ifc.pix_sof = 1'b0; ifc.pix_data = 16'hA001;
      tick;
      checks++;
      if (ifc.wr_din_vld !== 1'b1 || ifc.wr_din !== 16'hA000 || ifc.wr_req !== 1'b0) begin
         errors++;
         $display("FAIL first_din: got vld=%b din=%h req=%b want 1 a000 0", ifc.wr_din_vld, ifc.wr_din, ifc.wr_req);
      end
      for (int i = 2; i < 16; i++) begin
         ifc.pix_data = 16'hA000 + DW'(i);
         if (i == 15) begin
            checks++;
            if (ifc.frame_valid !== 1'b0) begin
               errors++;
               $display("FAIL early_commit: got frame_valid=%b want 0", ifc.frame_valid);
            end
         end
         tick;
      end
      checks++;
      if (ifc.frame_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_commit: got frame_valid=%b want 1", ifc.frame_valid);
      end
      ifc.pix_data = 16'hA0FF;
      repeat (3) tick;
      ifc.pix_vld = 1'b0;
      repeat (3) tick;
      checks++;
      if (din_q.size() - c_din != 16) begin
         errors++;
         $display("FAIL first_pix_count: got %0d want 16", din_q.size() - c_din);
      end else begin
         for (int i = 0; i < 16; i++)
            if (din_q[c_din + i] !== 16'hA000 + DW'(i)) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL first_pix_order: got %0d wrong pixels want 0", bad);
         end
      end
   endtask

   task automatic test_rotation;
      drive_frame(16'hB000, 16, 1'b0);
      checks++;
      if (req_beg !== 28'h100_0100) begin
         errors++;
         $display("FAIL rot_bank1: got %h want 1000100", req_beg);
      end
      drive_frame(16'hC000, 16, 1'b0);
      checks++;
      if (req_beg !== 28'h100_0200 || req_end !== 28'h100_0210) begin
         errors++;
         $display("FAIL rot_bank2: got %h/%h want 1000200/1000210", req_beg, req_end);
      end
   endtask

   task automatic test_read;
      tick;
      ifc.rd_frame_req = 1'b1;
      tick;
      ifc.rd_frame_req = 1'b0;
      checks++;
      if (ifc.rd_req !== 1'b1 || ifc.rd_address_begin !== 28'h100_0200 || ifc.rd_address_end !== 28'h100_0210) begin
         errors++;
         $display("FAIL read_last: got req=%b beg=%h end=%h want 1 1000200 1000210",
                  ifc.rd_req, ifc.rd_address_begin, ifc.rd_address_end);
      end
      tick;
      checks++;
      if (ifc.rd_req !== 1'b0) begin
         errors++;
         $display("FAIL read_pulse: got rd_req=%b want 0", ifc.rd_req);
      end
   endtask

   task automatic test_simul_commit;
      drive_frame(16'hD000, 16, 1'b1);
      checks++;
      if (req_beg !== 28'h100_0100) begin
         errors++;
         $display("FAIL simul_wr_bank: got %h want 1000100", req_beg);
      end
      checks++;
      if (ifc.rd_req !== 1'b1 || ifc.rd_address_begin !== 28'h100_0100 || ifc.rd_address_end !== 28'h100_0110) begin
         errors++;
         $display("FAIL simul_fwd: got req=%b beg=%h end=%h want 1 1000100 1000110",
                  ifc.rd_req, ifc.rd_address_begin, ifc.rd_address_end);
      end
      tick;
   endtask

   task automatic test_short_frame;
      int c_req = req_cnt;
      drive_frame(16'hF000, 10, 1'b0);
      checks++;
      if (req_beg !== 28'h100_0000) begin
         errors++;
         $display("FAIL simul_next_bank: got %h want 1000000", req_beg);
      end
      ifc.rd_frame_req = 1'b1;
      tick;
      ifc.rd_frame_req = 1'b0;
      checks++;
      if (ifc.rd_req !== 1'b1 || ifc.rd_address_begin !== 28'h100_0100) begin
         errors++;
         $display("FAIL short_no_commit: got req=%b beg=%h want 1 1000100", ifc.rd_req, ifc.rd_address_begin);
      end
      drive_frame(16'h1000, 16, 1'b0);
      checks++;
      if (req_cnt - c_req != 2 || req_beg !== 28'h100_0000) begin
         errors++;
         $display("FAIL short_restart: got %0d requests beg=%h want 2 1000000", req_cnt - c_req, req_beg);
      end
      checks++;
      if (ifc.drop_cnt !== EXP_DROP) begin
         errors++;
         $display("FAIL short_drop_cnt: got %0d want %0d", ifc.drop_cnt, EXP_DROP);
      end
      ifc.rd_frame_req = 1'b1;
      tick;
      ifc.rd_frame_req = 1'b0;
      checks++;
      if (ifc.rd_address_begin !== 28'h100_0000) begin
         errors++;
         $display("FAIL short_then_commit: got %h want 1000000", ifc.rd_address_begin);
      end
      tick;
   endtask

   task automatic test_calib_drop;
      int c_din, c_rd, c_req;
      drive_frame(16'h2000, 5, 1'b0);
      checks++;
      if (req_beg !== 28'h100_0200) begin
         errors++;
         $display("FAIL calib_pre_bank: got %h want 1000200", req_beg);
      end
      ifc.pix_vld = 1'b1; ifc.pix_data = 16'h2005;
      init_calib_complete = 1'b0;
      tick;
      checks++;
      if (ifc.frame_valid !== 1'b0 || ifc.wr_din_vld !== 1'b0) begin
         errors++;
         $display("FAIL calib_drop: got frame_valid=%b din_vld=%b want 0 0", ifc.frame_valid, ifc.wr_din_vld);
      end
      c_din = din_q.size();
      c_rd  = rd_cnt;
      ifc.rd_frame_req = 1'b1;
      tick;
      ifc.rd_frame_req = 1'b0;
      repeat (3) tick;
      checks++;
      if (din_q.size() != c_din || rd_cnt != c_rd || ifc.rd_address_begin !== 28'h100_0000) begin
         errors++;
         $display("FAIL calib_idle: got din=%0d rd=%0d beg=%h want 0 0 1000000",
                  din_q.size() - c_din, rd_cnt - c_rd, ifc.rd_address_begin);
      end
      c_req = req_cnt;
      init_calib_complete = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ifc.pix_vld = 1'b1; ifc.pix_sof = 1'b1; ifc.pix_data = 16'h2100 + DW'(i);
         tick;
      end
      ifc.pix_vld = 1'b0; ifc.pix_sof = 1'b0;
      checks++;
      if (req_cnt != c_req) begin
         errors++;
         $display("FAIL recal_delay: got %0d requests want 0", req_cnt - c_req);
      end
      drive_frame(16'h3000, 16, 1'b0);
      checks++;
      if (req_beg !== 28'h100_0000 || ifc.frame_valid !== 1'b1 || ifc.drop_cnt !== EXP_DROP) begin
         errors++;
         $display("FAIL recal_restart: got beg=%h fv=%b drop=%0d want 1000000 1 %0d",
                  req_beg, ifc.frame_valid, ifc.drop_cnt, EXP_DROP);
      end
   endtask

   task automatic test_back_to_back;
      repeat (2) tick;
      checks++;
      if (dbl_cnt != 0) begin
         errors++;
         $display("FAIL req_one_cycle: got %0d multi-cycle requests want 0", dbl_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_delay;
      test_first_frame;
      test_rotation;
      test_read;
      test_simul_commit;
      test_short_frame;
      test_calib_drop;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr3_frame_sched.md
# ddr3_frame_sched

Triple-buffer frame scheduler for the DDR3 native-FIFO write port. It sits between the RGB565 pixel source (UART image path) and the DDR3 write/read FIFO request interfaces, in the wr_clk domain. It gates startup on calibration, aligns each incoming frame to a `wr_req` burst, and rotates writes across three frame banks. It hands the display side the newest complete bank so reads never tear.

## Interface
Parameters:
- ADDR_WIDTH, 28, DDR3 address width
- DATA_IN_WIDTH, 16, pixel width
- FRAME_BASE, 28'h100_0000, bank 0 base address
- FRAME_STRIDE, 28'h010_0000, address distance between banks
- FRAME_PIX, 28'h00e_1000, pixels per frame (1280*720); end = begin + FRAME_PIX
- DELAY_TIME, 500, wr_clk cycles after calibration before any request

Ports (all synchronous to wr_clk):
- wr_clk  in  1  clock
- rst_n  in  1  reset; decided: synchronous, active-low, clock wr_clk
- init_calib_complete  in  1  MIG calibration done
- pix_data  in  DATA_IN_WIDTH  pixel
- pix_vld  in  1  pixel valid
- pix_sof  in  1  first pixel of frame; qualified by pix_vld
- wr_req  out  1  one-cycle write-burst request
- wr_address_begin / wr_address_end  out  ADDR_WIDTH each  write window
- wr_din  out  DATA_IN_WIDTH  pixel to write FIFO
- wr_din_vld  out  1  valid for wr_din
- rd_frame_req  in  1  display frame-start pulse, already synchronised to wr_clk
- rd_req  out  1  one-cycle read-burst request
- rd_address_begin / rd_address_end  out  ADDR_WIDTH each  read window
- frame_valid  out  1  at least one frame committed
- drop_cnt  out  16  aborted (short) frames, saturating

## Operation
- FSM states: IDLE, DELAY, WAIT_SOF, STREAM.
- IDLE: wait for init_calib_complete=1, then go to DELAY.
- DELAY: count to DELAY_TIME-1, then go to WAIT_SOF.
- WAIT_SOF: pixels without sof are discarded. On pix_vld&pix_sof, issue wr_req for wr_bank and go to STREAM.
- STREAM: forward pixels and count accepted pixels.
  - When count reaches FRAME_PIX: commit, go to WAIT_SOF.
  - Further pixels without sof are discarded.
- Commit actions:
  - last_bank <= wr_bank; frame_valid <= 1.
  - wr_bank <= lowest index in {0,1,2} not equal to rd_bank (post-update) and not equal to last_bank (new).
- Short frame: pix_sof arrives in STREAM with count < FRAME_PIX.
  - drop_cnt increments.
  - Frame restarts on the same wr_bank with a new wr_req.
  - No commit.
- Read side, on rd_frame_req:
  - If frame_valid: rd_bank <= last_bank; rd_req pulses; read addresses are updated.
  - Else: ignored, and outputs stay unchanged.
- Simultaneous commit and rd_frame_req: the read takes the newly committed bank (forwarded).
- Address arithmetic: begin = FRAME_BASE + bank*FRAME_STRIDE, ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH; end = begin + FRAME_PIX.
- init_calib_complete dropping in any state: return to IDLE next cycle. This clears the FSM, counters, frame_valid and bank indices; drop_cnt is kept.

## Timing
- Reset values:
  - wr_req=0, rd_req=0, wr_din_vld=0, frame_valid=0.
  - wr_din=0; all four address outputs = 0; drop_cnt=0.
  - wr_bank=0, rd_bank=0, last_bank=0; state IDLE.
- SOF pixel sampled at cycle T:
  - T+1: wr_req=1, with wr_address_begin/end already valid.
  - T+2: wr_din_vld=1 with the SOF pixel.
- All forwarded pixels have a fixed 2-cycle latency; pixel ordering is preserved.
- wr_address_* hold between requests.
- Commit happens on the cycle after the FRAME_PIX-th pixel is sampled.
- rd_frame_req at cycle R: rd_req=1 and new rd_address_* at R+1.
- wr_req and rd_req are never asserted for more than one consecutive cycle.
- Any same-cycle SOF restarts the frame, even a short-frame SOF.

## Configuration
- FRAME_SCHED_DROP_CNT_EN
  - Defined: drop_cnt counts short frames, saturating at 16'hFFFF.
  - Undefined: counter logic is removed; drop_cnt is tied to 0; short-frame restart behaviour is unchanged.

## Structure
- Package ddr3_frame_pkg holds:
  - FSM state encoding.
  - Bank index width (2) and bank count (3).
  - A bank-to-base-address function.
- Sub-module frame_bank_sel: combinational plus registered selection of next wr_bank and rd_bank, including the simultaneous-event forwarding.
- The top level holds the FSM, delay counter, pixel pipeline and address registers.

## Test plan
Bench settings: FRAME_PIX=16, DELAY_TIME=8, FRAME_STRIDE=28'h100.

- Reset, then calib high at t0 with pixels offered → no wr_req before t0+8, and no wr_din_vld from pixels before the first SOF.
- First SOF at T → wr_req at T+1 with begin=28'h100_0000, end=28'h100_0010; 16 wr_din_vld pulses starting at T+2; frame_valid=1 after commit.
- Three full frames, no read → writes go to banks 0,1,2 in turn (rd_bank=0 excluded after the first rotation); last_bank tracks each commit.
- rd_frame_req on the same cycle as bank-1 commit → rd_req at +1 with begin=28'h100_0100; the next write bank is 0 (lowest index not 1).
- SOF after 10 pixels → drop_cnt=1; same begin address re-requested; no commit. With the macro undefined, drop_cnt stays 0.
- init_calib_complete dropped mid-STREAM → IDLE next cycle; frame_valid=0; no wr_din_vld; full restart after recalibration plus the delay.
